shift_cmd_sched: RTL and testbench
==================================

Name: shift_cmd_sched

Overview:
- Command scheduler in front of the 8-digit seven-segment display shift buffer.
- Accepts "append character", "backspace" and "clear" requests from the Morse decoder and button debouncers, and queues them in a small FIFO.
- Replays queued commands to the shift buffer one at a time, honouring its pipeline: 2-stage edge sync on flag/backspace, and a GAP-cycle commit delay during which direction must stay 0.
- Tracks how many digits are currently shown.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2).
- GAP, 1000000, buffer commit delay in clk cycles after a flag edge.
- STB, 4, strobe high time in cycles (≥2 so both sync stages see it).

Ports:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- char_valid  in  1  one-cycle pulse: append char_code
- char_code  in  4  hex digit to append
- bs_req  in  1  one-cycle pulse: backspace
- clr_req  in  1  one-cycle pulse: clear display
- sh_dir  out  1  to buffer direction (0 = flag path, 1 = backspace path)
- sh_flag  out  1  to buffer flag
- sh_bs  out  1  to buffer bs_button
- sh_code  out  4  to buffer in
- sh_clr  out  1  to buffer rst, one-cycle pulse
- busy  out  1  FSM not IDLE or FIFO non-empty
- count  out  4  digits displayed, 0..8
- drop  out  1  one-cycle pulse when a request is discarded

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Reset is asynchronous. Asserting it mid-operation aborts the current command and flushes the FIFO.
- FIFO entry format: {op[0]: 0 = char, 1 = bs, code[3:0]}. Push happens on the request cycle.
- Same-cycle priority: clr_req > bs_req > char_valid.
  - Losing requests are discarded.
  - drop pulses once per cycle in which any request was discarded.
- FIFO full: new char or bs is discarded and drop pulses. clr is never blocked.
- clr_req effect, next cycle:
  - FIFO flushed, in-flight command aborted, state returns to IDLE.
  - sh_clr pulses high for 1 cycle; count becomes 0.
  - sh_flag, sh_bs and sh_dir are forced to 0.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the entry into the command register, go to SETUP.
  - SETUP, 2 cycles:
    - Drive sh_dir = op and sh_code = code.
    - Strobes stay low.
    - Skip rule: if op = bs and count = 0, the entry is dropped silently (no drop pulse) and the FSM returns to IDLE with no strobe issued.
  - STROBE, STB cycles: sh_flag = ~op, sh_bs = op; sh_dir and sh_code held.
  - HOLD, then IDLE:
    - Strobes low; sh_dir and sh_code held.
    - Duration is GAP+3 cycles for char (covers sync latency plus commit), or 3 cycles for bs.
    - On leaving HOLD, count is updated: char → count = min(count + 1, 8); bs → count − 1.
- sh_dir and sh_code hold their last command's values while in IDLE.
- Command spacing: consecutive commands are separated by at least 1 IDLE cycle.
- HOLD counter is wide enough for GAP+3; $clog2 sizing.
- No combinational path from request inputs to sh_* outputs. All sh_* outputs are registered.

Optional Feature:
- Macro: SHIFT_CMD_SCHED_STATS_EN.
- When defined, adds three outputs:
  - stat_chars (16 bits): count of char commands issued.
  - stat_bs (16 bits): count of bs commands issued, excluding skipped ones.
  - stat_drops (8 bits): count of drop pulses.
- All three counters saturate, reset to 0 on rst, and are unaffected by clr_req.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- GAP=8, STB=4: reset, then char_valid with code 4'h5 → sh_dir=0, sh_code=5 for 2 cycles, then sh_flag high 4 cycles, then HOLD 11 cycles; count becomes 1; busy falls 1 cycle later.
- Three chars (1, 2, 3) pushed on consecutive cycles → three flag strobes in order 1, 2, 3, each separated by ≥ SETUP+STROBE+HOLD+1 cycles; count = 3; no drop.
- count=0: bs_req → no sh_bs strobe, count stays 0, no drop. Then one char followed by bs → one flag strobe, then one sh_bs strobe; final count = 0.
- DEPTH=4: 6 char pulses in 6 cycles while busy → the first is popped immediately and 4 fill the FIFO, so exactly 1 drop pulse; 5 chars issued total.
- Nine chars → count saturates at 8. Then clr_req mid-HOLD → sh_clr pulses once, strobes at 0, count = 0, FIFO empty, busy = 0.
- Same cycle char_valid + bs_req → only bs queued, drop = 1. rst asserted during STROBE → all outputs 0 immediately.

Source files
------------

// File: rtl/shift_cmd_sched.sv
// shift_cmd_sched: command scheduler in front of the 8-digit seven-segment
// shift buffer. Append/backspace requests are queued in a small FIFO and
// replayed one at a time. Each command goes through SETUP (direction and code
// settle, 2 cycles), STROBE (flag or bs high for STB cycles) and HOLD (buffer
// sync + commit latency). A clear request flushes everything, aborts the
// in-flight command and pulses the buffer reset.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   char_valid/char_code  append request (pulse) and hex digit
//   bs_req, clr_req     backspace / clear requests (pulses)
//   sh_dir, sh_flag, sh_bs, sh_code, sh_clr   registered buffer controls
//   busy                FSM active or FIFO non-empty
//   count               digits currently shown (0..8)
//   drop                pulse for any cycle in which a request was discarded
//
// Optional: define SHIFT_CMD_SCHED_STATS_EN to add the saturating counters
// stat_chars, stat_bs and stat_drops.
module shift_cmd_sched #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1000000,
  parameter int STB   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [3:0] char_code,
  input  logic       bs_req,
  input  logic       clr_req,
  output logic       sh_dir,
  output logic       sh_flag,
  output logic       sh_bs,
  output logic [3:0] sh_code,
  output logic       sh_clr,
  output logic       busy,
  output logic [3:0] count,
  output logic       drop
`ifdef SHIFT_CMD_SCHED_STATS_EN
  ,
  output logic [15:0] stat_chars,
  output logic [15:0] stat_bs,
  output logic [7:0]  stat_drops
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(GAP + STB + 4);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [TW-1:0]            tmr_q, tmr_d;
  logic                     op_q, op_d;
  logic [3:0]               sh_code_q, sh_code_d;
  logic                     sh_dir_q, sh_dir_d;
  logic                     sh_flag_q, sh_flag_d;
  logic                     sh_bs_q, sh_bs_d;
  logic                     sh_clr_q, sh_clr_d;
  logic [3:0]               count_q, count_d;
  logic                     drop_q, drop_d;
  logic [DEPTH-1:0][4:0]    fifo_q, fifo_d;
  logic [AW:0]              wr_q, wr_d, rd_q, rd_d;
  logic                     empty, full, push, issue;
  logic [4:0]               push_ent, head;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = fifo_q[rd_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    op_d      = op_q;
    sh_code_d = sh_code_q;
    sh_dir_d  = sh_dir_q;
    sh_flag_d = sh_flag_q;
    sh_bs_d   = sh_bs_q;
    sh_clr_d  = 1'b0;
    count_d   = count_q;
    drop_d    = 1'b0;
    fifo_d    = fifo_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    push      = 1'b0;
    push_ent  = 5'd0;
    issue     = 1'b0;

    if (clr_req) begin
      // Clear wins; anything else this cycle is lost.
      drop_d    = bs_req | char_valid;
      state_d   = IDLE;
      wr_d      = '0;
      rd_d      = '0;
      sh_clr_d  = 1'b1;
      count_d   = 4'd0;
      sh_flag_d = 1'b0;
      sh_bs_d   = 1'b0;
      sh_dir_d  = 1'b0;
    end else begin
      if (bs_req) begin
        drop_d   = char_valid | full;
        push     = ~full;
        push_ent = {1'b1, 4'h0};
      end else if (char_valid) begin
        drop_d   = full;
        push     = ~full;
        push_ent = {1'b0, char_code};
      end

      case (state_q)
        IDLE: if (!empty) begin
          op_d      = head[4];
          sh_dir_d  = head[4];
          sh_code_d = head[3:0];
          rd_d      = rd_q + 1'b1;
          tmr_d     = TW'(1);
          state_d   = SETUP;
        end
        SETUP: if (tmr_q == '0) begin
          // Backspace on an empty display is silently skipped.
          if (op_q && count_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            issue     = 1'b1;
            state_d   = STROBE;
            tmr_d     = TW'(STB - 1);
            sh_flag_d = ~op_q;
            sh_bs_d   = op_q;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
        STROBE: if (tmr_q == '0) begin
          state_d   = HOLD;
          tmr_d     = op_q ? TW'(2) : TW'(GAP + 2);
          sh_flag_d = 1'b0;
          sh_bs_d   = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
        HOLD: if (tmr_q == '0) begin
          state_d = IDLE;
          if (op_q)                 count_d = count_q - 1'b1;
          else if (count_q != 4'd8) count_d = count_q + 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (push) begin
        fifo_d[wr_q[AW-1:0]] = push_ent;
        wr_d = wr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      op_q      <= 1'b0;
      sh_code_q <= 4'd0;
      sh_dir_q  <= 1'b0;
      sh_flag_q <= 1'b0;
      sh_bs_q   <= 1'b0;
      sh_clr_q  <= 1'b0;
      count_q   <= 4'd0;
      drop_q    <= 1'b0;
      fifo_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      op_q      <= op_d;
      sh_code_q <= sh_code_d;
      sh_dir_q  <= sh_dir_d;
      sh_flag_q <= sh_flag_d;
      sh_bs_q   <= sh_bs_d;
      sh_clr_q  <= sh_clr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      fifo_q    <= fifo_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  assign sh_dir  = sh_dir_q;
  assign sh_flag = sh_flag_q;
  assign sh_bs   = sh_bs_q;
  assign sh_code = sh_code_q;
  assign sh_clr  = sh_clr_q;
  assign count   = count_q;
  assign drop    = drop_q;
  assign busy    = (state_q != IDLE) | ~empty;

`ifdef SHIFT_CMD_SCHED_STATS_EN
  logic [15:0] stat_chars_q, stat_chars_d, stat_bs_q, stat_bs_d;
  logic [7:0]  stat_drops_q, stat_drops_d;

  // Saturating; clr_req deliberately leaves these alone.
  always_comb begin
    stat_chars_d = stat_chars_q;
    stat_bs_d    = stat_bs_q;
    stat_drops_d = stat_drops_q;
    if (issue && !op_q && stat_chars_q != 16'hffff) stat_chars_d = stat_chars_q + 1'b1;
    if (issue &&  op_q && stat_bs_q    != 16'hffff) stat_bs_d    = stat_bs_q + 1'b1;
    if (drop_d && stat_drops_q != 8'hff)            stat_drops_d = stat_drops_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_chars_q <= '0;
      stat_bs_q    <= '0;
      stat_drops_q <= '0;
    end else begin
      stat_chars_q <= stat_chars_d;
      stat_bs_q    <= stat_bs_d;
      stat_drops_q <= stat_drops_d;
    end
  end

  assign stat_chars = stat_chars_q;
  assign stat_bs    = stat_bs_q;
  assign stat_drops = stat_drops_q;
`endif

endmodule

// File: tb/tb_shift_cmd_sched.sv
// Bench for shift_cmd_sched (GAP=8, STB=4, DEPTH=4). A queue-and-phase model
// predicts every output each cycle; directed tests add literal expectations.
module tb_shift_cmd_sched;
  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int STB   = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic char_valid = 1'b0, bs_req = 1'b0, clr_req = 1'b0;
  logic [3:0] char_code = 4'd0;
  logic sh_dir, sh_flag, sh_bs, sh_clr, busy, drop;
  logic [3:0] sh_code, count;

  always #5 clk = ~clk;

  shift_cmd_sched #(.DEPTH(DEPTH), .GAP(GAP), .STB(STB)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .bs_req(bs_req), .clr_req(clr_req), .sh_dir(sh_dir), .sh_flag(sh_flag),
    .sh_bs(sh_bs), .sh_code(sh_code), .sh_clr(sh_clr), .busy(busy),
    .count(count), .drop(drop)
  );

  int vecs = 0, errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: queue of pending entries + phase of active cmd
  logic [4:0] mq[$];
  logic [4:0] ent;
  bit   act_m, mop, mdir, mdrop, mclr, mfull;
  int   k, mcount;
  logic [3:0] mcode;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); act_m = 0; k = 0; mop = 0; mdir = 0; mcode = 4'd0;
      mcount = 0; mdrop = 0; mclr = 0;
    end else begin
      mfull = (mq.size() == DEPTH);
      mdrop = 0; mclr = 0;
      if (clr_req) begin
        mdrop = bs_req | char_valid;
        mq.delete(); act_m = 0; mcount = 0; mclr = 1; mdir = 0;
      end else begin
        if (act_m) begin
          k++;
          if (k == 2 && mop && mcount == 0) act_m = 0;
          else if (k == 2 + STB + (mop ? 3 : GAP + 3)) begin
            act_m = 0;
            mcount = mop ? mcount - 1 : (mcount < 8 ? mcount + 1 : 8);
          end
        end else if (mq.size() > 0) begin
          ent = mq.pop_front();
          act_m = 1; k = 0; mop = ent[4]; mdir = ent[4]; mcode = ent[3:0];
        end
        if (bs_req) begin
          mdrop = char_valid | mfull;
          if (!mfull) mq.push_back(5'h10);
        end else if (char_valid) begin
          mdrop = mfull;
          if (!mfull) mq.push_back({1'b0, char_code});
        end
      end
    end
  end

  // ---------------- per-cycle compare + event monitor
  int flag_cnt = 0, bs_cnt = 0, drop_cnt = 0, clr_cnt = 0;
  int run = 0, last_len = 0, hold_run = 0, last_hold = 0;
  bit prev_stb = 0, after_stb = 0, prev_flag = 0, prev_bs = 0;
  logic [3:0] codes[$];
  logic [13:0] exp_v, dut_v;
  bit in_strobe;

  always @(posedge clk) begin
    #1;
    in_strobe = act_m && k >= 2 && k < 2 + STB;
    exp_v = {mdir, in_strobe && !mop, in_strobe && mop, mcode, mclr,
             act_m || (mq.size() > 0), 4'(mcount), mdrop};
    dut_v = {sh_dir, sh_flag, sh_bs, sh_code, sh_clr, busy, count, drop};
    check("cycle_outputs", 32'(dut_v), 32'(exp_v));
    if (!rst) begin
      if (sh_flag && !prev_flag) begin flag_cnt++; codes.push_back(sh_code); end
      if (sh_bs && !prev_bs) bs_cnt++;
      if (drop) drop_cnt++;
      if (sh_clr) clr_cnt++;
      if (sh_flag || sh_bs) run++;
      else if (prev_stb) begin last_len = run; run = 0; after_stb = 1; hold_run = 0; end
      if (after_stb) begin
        if (busy && !sh_flag && !sh_bs) hold_run++;
        else begin after_stb = 0; last_hold = hold_run; end
      end
      prev_stb = sh_flag || sh_bs; prev_flag = sh_flag; prev_bs = sh_bs;
    end
  end

  // ---------------- stimulus helpers
  task automatic drive(input bit c, input logic [3:0] cd, input bit b, input bit cl);
    @(negedge clk);
    char_valid = c; char_code = cd; bs_req = b; clr_req = cl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 4'd0, 0, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    idle(1);
    while (busy && n < budget) begin idle(1); n++; end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_flag(input int budget);
    int n = 0;
    while (!sh_flag && n < budget) begin idle(1); n++; end
    check("wait_flag_timeout", 32'(sh_flag), 32'd1);
  endtask

  task automatic do_clr();
    drive(0, 4'd0, 0, 1);
    idle(2);
  endtask

  int f0, b0, d0, c0, cb;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({sh_dir, sh_flag, sh_bs, sh_code, sh_clr, busy, count, drop}), 32'd0);
    rst = 1'b0;
    idle(2);

    // single char 5
    f0 = flag_cnt; d0 = drop_cnt;
    drive(1, 4'h5, 0, 0);
    wait_idle(60);
    check("t1_count", 32'(count), 32'd1);
    check("t1_flags", 32'(flag_cnt - f0), 32'd1);
    check("t1_code", 32'(codes[codes.size()-1]), 32'h5);
    check("t1_strobe_len", 32'(last_len), 32'd4);
    check("t1_hold_len", 32'(last_hold), 32'd11);
    check("t1_drops", 32'(drop_cnt - d0), 32'd0);

    // three chars back to back
    do_clr();
    check("t2_cleared", 32'(count), 32'd0);
    f0 = flag_cnt; d0 = drop_cnt; cb = codes.size();
    drive(1, 4'h1, 0, 0); drive(1, 4'h2, 0, 0); drive(1, 4'h3, 0, 0);
    wait_idle(200);
    check("t2_count", 32'(count), 32'd3);
    check("t2_flags", 32'(flag_cnt - f0), 32'd3);
    check("t2_code0", 32'(codes[cb]), 32'h1);
    check("t2_code1", 32'(codes[cb+1]), 32'h2);
    check("t2_code2", 32'(codes[cb+2]), 32'h3);
    check("t2_drops", 32'(drop_cnt - d0), 32'd0);

    // bs on empty display is skipped, then char + bs
    do_clr();
    b0 = bs_cnt; d0 = drop_cnt; f0 = flag_cnt;
    drive(0, 4'd0, 1, 0);
    wait_idle(50);
    check("t3_skip_count", 32'(count), 32'd0);
    check("t3_skip_bs", 32'(bs_cnt - b0), 32'd0);
    check("t3_skip_drop", 32'(drop_cnt - d0), 32'd0);
    drive(1, 4'h7, 0, 0); drive(0, 4'd0, 1, 0);
    wait_idle(100);
    check("t3_count", 32'(count), 32'd0);
    check("t3_flags", 32'(flag_cnt - f0), 32'd1);
    check("t3_bs", 32'(bs_cnt - b0), 32'd1);

    // FIFO overflow: 6 chars in 6 cycles
    do_clr();
    f0 = flag_cnt; d0 = drop_cnt;
    for (int i = 1; i <= 6; i++) drive(1, 4'(i), 0, 0);
    wait_idle(300);
    check("t4_drops", 32'(drop_cnt - d0), 32'd1);
    check("t4_flags", 32'(flag_cnt - f0), 32'd5);
    check("t4_count", 32'(count), 32'd5);
    check("t4_last_code", 32'(codes[codes.size()-1]), 32'h5);

    // saturation at 8, then clear mid-HOLD
    do_clr();
    for (int i = 0; i < 9; i++) begin
      drive(1, 4'(i), 0, 0);
      wait_idle(60);
    end
    check("t5_sat_count", 32'(count), 32'd8);
    c0 = clr_cnt;
    drive(1, 4'h9, 0, 0);
    wait_flag(20);
    idle(STB + 3);
    check("t5_in_hold", 32'({busy, sh_flag, sh_bs}), 32'b100);
    drive(0, 4'd0, 0, 1);
    idle(1);
    check("t5_clr_pulse", 32'(sh_clr), 32'd1);
    check("t5_clr_state", 32'({busy, sh_flag, sh_bs, sh_dir, count}), 32'd0);
    idle(1);
    check("t5_clr_once", 32'(clr_cnt - c0), 32'd1);
    check("t5_clr_low", 32'(sh_clr), 32'd0);

    // same-cycle char + bs: bs wins, one drop
    do_clr();
    drive(1, 4'h3, 0, 0);
    wait_idle(60);
    f0 = flag_cnt; b0 = bs_cnt; d0 = drop_cnt;
    drive(1, 4'h4, 1, 0);
    wait_idle(60);
    check("t6_drops", 32'(drop_cnt - d0), 32'd1);
    check("t6_flags", 32'(flag_cnt - f0), 32'd0);
    check("t6_bs", 32'(bs_cnt - b0), 32'd1);
    check("t6_count", 32'(count), 32'd0);

    // async reset during STROBE
    drive(1, 4'h6, 0, 0);
    wait_flag(20);
    #2 rst = 1'b1;
    #1 check("t6_async_rst", 32'({sh_dir, sh_flag, sh_bs, sh_code, sh_clr, busy, count, drop}), 32'd0);
    @(negedge clk) rst = 1'b0;
    idle(3);
    check("t6_after_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vecs, errs);
    $fatal(1);
  end
endmodule
